axil_adapter_rd: RTL and testbench
==================================

Name: axil_adapter_rd

Overview:
- AXI4-lite read-path width adapter: converts AR/R traffic between a slave interface of S_DATA_WIDTH and a master interface of M_DATA_WIDTH.
- Companion to the write-path width adapter; the two are paired under a full AXI-lite width adapter.
- Master wider: single read, lane-select on return.
- Master narrower: one slave read is split into SEGMENT_COUNT sequential master reads, and the returned data is reassembled.

Parameters:
ADDR_WIDTH, 32, address bus width
S_DATA_WIDTH, 32, slave data width
S_STRB_WIDTH, S_DATA_WIDTH/8, slave byte lanes
M_DATA_WIDTH, 32, master data width
M_STRB_WIDTH, M_DATA_WIDTH/8, master byte lanes

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous reset, active-low (asserted at 0); release is sampled on clk
s_axil_araddr  in  ADDR_WIDTH  slave read address
s_axil_arprot  in  3  slave protection
s_axil_arvalid  in  1  slave AR valid
s_axil_arready  out  1  slave AR ready
s_axil_rdata  out  S_DATA_WIDTH  slave read data
s_axil_rresp  out  2  slave read response
s_axil_rvalid  out  1  slave R valid
s_axil_rready  in  1  slave R ready
m_axil_araddr  out  ADDR_WIDTH  master read address
m_axil_arprot  out  3  master protection
m_axil_arvalid  out  1  master AR valid
m_axil_arready  in  1  master AR ready
m_axil_rdata  in  M_DATA_WIDTH  master read data
m_axil_rresp  in  2  master read response
m_axil_rvalid  in  1  master R valid
m_axil_rready  out  1  master R ready

Behaviour:
- Elaboration checks (error + finish):
  - data widths divisible by strb widths;
  - equal word size on both sides;
  - strb widths are powers of two.
- Derived values:
  - EXPAND = M_STRB_WIDTH > S_STRB_WIDTH.
  - SEGMENT_COUNT = wider/narrower strb ratio.
  - S_ADDR_BIT_OFFSET = clog2(S_STRB_WIDTH); M_ADDR_BIT_OFFSET = clog2(M_STRB_WIDTH).
- Reset: every register, including data, clears asynchronously on rst=0, so all outputs are 0 and the state is IDLE.
- Outputs: all are registered; no combinational path from input to output.
- FSM has two states, IDLE and DATA.
- IDLE:
  - s_axil_arready_next = !m_axil_arvalid, so arready rises the first clock after reset release.
  - Narrow mode also clears segment=0 and resp_acc=0.
  - On s AR handshake:
    - drop arready;
    - load m_axil_araddr (EXPAND or equal width: unchanged; narrow: s_axil_araddr with low S_ADDR_BIT_OFFSET bits cleared);
    - copy arprot; m_axil_arvalid=1; m_axil_rready_next=!s_axil_rvalid; go to DATA.
- m_axil_arvalid holds until m_axil_arready; it is independent of R.
- DATA:
  - m_axil_rready_next = !s_axil_rvalid; rready is never high while s_axil_rvalid is pending.
  - On m R handshake, equal width: s_axil_rdata = m_axil_rdata.
  - On m R handshake, EXPAND: s_axil_rdata = m_axil_rdata >> (m_axil_araddr[M_ADDR_BIT_OFFSET-1:S_ADDR_BIT_OFFSET] * S_DATA_WIDTH).
  - Equal width and EXPAND then: s_axil_rresp = m_axil_rresp; s_axil_rvalid=1; arready_next=!m_axil_arvalid; go to IDLE.
  - Narrow mode, on each beat:
    - write m_axil_rdata into s_axil_rdata segment [segment*M_DATA_WIDTH +: M_DATA_WIDTH];
    - if m_axil_rresp != 0, resp_acc = m_axil_rresp (latest nonzero wins).
  - Narrow mode, if segment == SEGMENT_COUNT-1: s_axil_rresp = accumulated resp; s_axil_rvalid=1; return to IDLE.
  - Narrow mode, else:
    - segment+1;
    - m_axil_araddr += M_STRB_WIDTH (no wrap masking; address arithmetic is modulo 2^ADDR_WIDTH);
    - m_axil_arvalid=1; stay in DATA.
- Rvalid hold: s_axil_rvalid, s_axil_rdata and s_axil_rresp hold stable until s_axil_rready; s_axil_rvalid_next = rvalid && !rready.
- Overlap with a pending response:
  - A new AR may be accepted while s_axil_rvalid is still pending.
  - m_axil_rready stays low until the slave consumes the response.
  - The slave-side data register is written only when rready is asserted, i.e. after the pending response has drained.
- Simultaneous master rvalid and arvalid: the address is independent; an early R beat is legal only after AR completes per protocol and needs no extra handling.
- Reset mid-transaction: state returns to IDLE, valids and readies go to 0 immediately, and the in-flight transaction is dropped.
- Latency (zero-wait master, rready=1): s AR handshake edge N → m_axil_arvalid high N+1.
  - Equal/EXPAND: master R at N+2 → s_axil_rvalid high N+3.
  - Narrow: each extra segment adds 2 cycles.

Test Plan:
- S=32, M=64, read 0x1004, master returns 0xAAAABBBB_CCCCDDDD OKAY → m_araddr=0x1004; s_rdata=0xAAAABBBB; s_rresp=0. Read 0x1000 returns 0xCCCCDDDD.
- S=64, M=32, read 0x1004 → master reads 0x1000 then 0x1004; data 0x11111111, 0x22222222 → s_rdata=0x22222222_11111111; exactly one s_rvalid pulse.
- S=64, M=32, beat 0 OKAY, beat 1 SLVERR(2) → s_rresp=2; with beat 0 DECERR(3) and beat 1 OKAY → s_rresp=3.
- Backpressure, S=M=32: s_rready low for 5 cycles → s_rvalid/s_rdata stable, m_rready=0, a second AR is accepted but is not completed until rready; both responses are delivered in order with correct data.
- Master AR stall: m_arready low for 4 cycles → m_arvalid and m_araddr held; s_arready=0 throughout.
- Reset: assert rst=0 in DATA, async → all valid/ready outputs 0 before the next edge; after release, s_arready=1 one cycle later and a fresh read completes correctly.

Source files
------------

// File: rtl/axil_adapter_rd.sv
// AXI4-lite read-path width adapter between a slave port of S_DATA_WIDTH and a
// master port of M_DATA_WIDTH. A wider master is read once and lane-selected;
// a narrower master is read in SEGMENT_COUNT consecutive beats that are reassembled.
module axil_adapter_rd #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned S_DATA_WIDTH = 32,
  parameter int unsigned S_STRB_WIDTH = S_DATA_WIDTH / 8,
  parameter int unsigned M_DATA_WIDTH = 32,
  parameter int unsigned M_STRB_WIDTH = M_DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   s_axil_araddr,
  input  logic [2:0]              s_axil_arprot,
  input  logic                    s_axil_arvalid,
  output logic                    s_axil_arready,
  output logic [S_DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]              s_axil_rresp,
  output logic                    s_axil_rvalid,
  input  logic                    s_axil_rready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [M_DATA_WIDTH-1:0] m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready
);

  localparam int unsigned S_ADDR_BIT_OFFSET = $clog2(S_STRB_WIDTH);
  localparam int unsigned M_ADDR_BIT_OFFSET = $clog2(M_STRB_WIDTH);
  localparam bit          EXPAND            = M_STRB_WIDTH > S_STRB_WIDTH;
  localparam bit          NARROW            = S_STRB_WIDTH > M_STRB_WIDTH;
  localparam int unsigned SEGMENT_COUNT     = EXPAND ? (M_STRB_WIDTH / S_STRB_WIDTH)
                                                     : (S_STRB_WIDTH / M_STRB_WIDTH);
  localparam int unsigned SEG_W             = (SEGMENT_COUNT > 1) ? $clog2(SEGMENT_COUNT) : 1;
  localparam logic [ADDR_WIDTH-1:0]   S_ADDR_MASK = {ADDR_WIDTH{1'b1}} << S_ADDR_BIT_OFFSET;
  localparam logic [S_DATA_WIDTH-1:0] SEG_MASK    = S_DATA_WIDTH'({M_DATA_WIDTH{1'b1}});

  // Reject parameter sets the lane arithmetic cannot represent
  if (S_STRB_WIDTH * (S_DATA_WIDTH / S_STRB_WIDTH) != S_DATA_WIDTH ||
      M_STRB_WIDTH * (M_DATA_WIDTH / M_STRB_WIDTH) != M_DATA_WIDTH) begin : g_chk_div
    $fatal(1, "axil_adapter_rd: data width not evenly divisible by strobe width");
  end
  if (S_DATA_WIDTH / S_STRB_WIDTH != M_DATA_WIDTH / M_STRB_WIDTH) begin : g_chk_word
    $fatal(1, "axil_adapter_rd: word size differs between slave and master");
  end
  if ((S_STRB_WIDTH & (S_STRB_WIDTH - 1)) != 0 ||
      (M_STRB_WIDTH & (M_STRB_WIDTH - 1)) != 0) begin : g_chk_pow2
    $fatal(1, "axil_adapter_rd: strobe widths must be powers of two");
  end

  typedef enum logic {IDLE = 1'b0, DATA = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic                    s_arready_q, s_arready_d;
  logic [ADDR_WIDTH-1:0]   m_araddr_q, m_araddr_d;
  logic [2:0]              m_arprot_q, m_arprot_d;
  logic                    m_arvalid_q, m_arvalid_d;
  logic                    m_rready_q, m_rready_d;
  logic [S_DATA_WIDTH-1:0] s_rdata_q, s_rdata_d;
  logic [1:0]              s_rresp_q, s_rresp_d;
  logic                    s_rvalid_q, s_rvalid_d;
  logic [SEG_W-1:0]        segment_q, segment_d;
  logic [1:0]              resp_acc_q, resp_acc_d;

  logic                    s_ar_hs_c;
  logic                    m_r_hs_c;
  logic                    last_seg_c;
  logic [SEG_W-1:0]        lane_c;
  logic [31:0]             seg_shift_c;
  logic [1:0]              resp_new_c;

  assign s_ar_hs_c   = s_arready_q & s_axil_arvalid;
  assign m_r_hs_c    = m_rready_q & m_axil_rvalid;
  assign last_seg_c  = !NARROW || (segment_q == SEG_W'(SEGMENT_COUNT - 1));
  assign seg_shift_c = 32'(segment_q) * M_DATA_WIDTH;
  // Latest non-OKAY response of the beats seen so far wins
  assign resp_new_c  = (m_axil_rresp != 2'd0) ? m_axil_rresp : resp_acc_q;

  // Slave lane within the wide master word, taken from the forwarded address
  if (EXPAND) begin : g_lane
    assign lane_c = m_araddr_q[M_ADDR_BIT_OFFSET-1:S_ADDR_BIT_OFFSET];
  end else begin : g_lane0
    assign lane_c = '0;
  end

  // State register and all registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      s_arready_q <= 1'b0;
      m_araddr_q  <= '0;
      m_arprot_q  <= 3'd0;
      m_arvalid_q <= 1'b0;
      m_rready_q  <= 1'b0;
      s_rdata_q   <= '0;
      s_rresp_q   <= 2'd0;
      s_rvalid_q  <= 1'b0;
      segment_q   <= '0;
      resp_acc_q  <= 2'd0;
    end else begin
      state_q     <= state_d;
      s_arready_q <= s_arready_d;
      m_araddr_q  <= m_araddr_d;
      m_arprot_q  <= m_arprot_d;
      m_arvalid_q <= m_arvalid_d;
      m_rready_q  <= m_rready_d;
      s_rdata_q   <= s_rdata_d;
      s_rresp_q   <= s_rresp_d;
      s_rvalid_q  <= s_rvalid_d;
      segment_q   <= segment_d;
      resp_acc_q  <= resp_acc_d;
    end
  end

  // Next state: leave IDLE on slave AR, return after the final master beat
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (s_ar_hs_c) state_d = DATA;
      DATA:    if (m_r_hs_c && last_seg_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the handshake, address and data registers
  always_comb begin
    s_arready_d = s_arready_q;
    m_araddr_d  = m_araddr_q;
    m_arprot_d  = m_arprot_q;
    m_arvalid_d = m_arvalid_q && !m_axil_arready;
    m_rready_d  = 1'b0;
    s_rdata_d   = s_rdata_q;
    s_rresp_d   = s_rresp_q;
    s_rvalid_d  = s_rvalid_q && !s_axil_rready;
    segment_d   = segment_q;
    resp_acc_d  = resp_acc_q;
    case (state_q)
      IDLE: begin
        s_arready_d = !m_arvalid_q;
        if (NARROW) begin
          segment_d  = '0;
          resp_acc_d = 2'd0;
        end
        if (s_ar_hs_c) begin
          s_arready_d = 1'b0;
          m_araddr_d  = NARROW ? (s_axil_araddr & S_ADDR_MASK) : s_axil_araddr;
          m_arprot_d  = s_axil_arprot;
          m_arvalid_d = 1'b1;
          m_rready_d  = !s_rvalid_q;
        end
      end
      DATA: begin
        // Hold off the master until any pending slave response has drained
        m_rready_d = !s_rvalid_q;
        if (m_r_hs_c) begin
          if (NARROW) begin
            s_rdata_d  = (s_rdata_q & ~(SEG_MASK << seg_shift_c)) |
                         (S_DATA_WIDTH'(m_axil_rdata) << seg_shift_c);
            resp_acc_d = resp_new_c;
          end else begin
            s_rdata_d  = S_DATA_WIDTH'(m_axil_rdata >> (32'(lane_c) * S_DATA_WIDTH));
          end
          if (last_seg_c) begin
            s_rresp_d   = NARROW ? resp_new_c : m_axil_rresp;
            s_rvalid_d  = 1'b1;
            m_rready_d  = 1'b0;
            s_arready_d = !m_arvalid_q;
          end else begin
            segment_d   = segment_q + SEG_W'(1);
            m_araddr_d  = m_araddr_q + ADDR_WIDTH'(M_STRB_WIDTH);
            m_arvalid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  assign s_axil_arready = s_arready_q;
  assign s_axil_rdata   = s_rdata_q;
  assign s_axil_rresp   = s_rresp_q;
  assign s_axil_rvalid  = s_rvalid_q;
  assign m_axil_araddr  = m_araddr_q;
  assign m_axil_arprot  = m_arprot_q;
  assign m_axil_arvalid = m_arvalid_q;
  assign m_axil_rready  = m_rready_q;

endmodule

// File: tb/tb_axil_adapter_rd.sv
// Scoreboard bench for axil_adapter_rd: five width pairings run side by side,
// each with a random slave-side reader and a random-latency master memory.
module tb_axil_adapter_rd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  typedef struct {
    logic [127:0] data;
    logic [1:0]   resp;
  } s_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [2:0]  prot;
  } m_exp_t;

  // Contents of the backing memory, one 32-bit word per aligned address
  function automatic logic [31:0] mem32(input logic [31:0] a);
    logic [31:0] w;
    w = a >> 2;
    return (w * 32'h9E37_79B1) ^ 32'h5BD1_E995 ^ (w << 7);
  endfunction

  // Response returned for a master word at aligned address a (mostly OKAY)
  function automatic logic [1:0] respfn(input logic [31:0] a);
    logic [31:0] h;
    h = (a >> 2) * 32'h85EB_CA6B + 32'h1234_5677;
    if (h[31:28] < 4'd11) return 2'd0;
    return 2'(32'd1 + (32'(h[31:28]) % 32'd3));
  endfunction

  // Bus word of nbytes width containing byte address a
  function automatic logic [127:0] busword(input logic [31:0] a, input int unsigned nbytes);
    logic [127:0] w;
    logic [31:0]  base;
    w    = '0;
    base = a & ~(nbytes - 32'd1);
    for (int i = 0; i < int'(nbytes / 4); i++) w[i*32 +: 32] = mem32(base + 32'(4 * i));
    return w;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  for (genvar g = 0; g < 5; g++) begin : g_cfg
    localparam int unsigned SDW    = (g == 1) ? 64 : (g == 3) ? 128 : 32;
    localparam int unsigned MDW    = (g == 0) ? 64 : (g == 4) ? 128 : 32;
    localparam int unsigned SB     = SDW / 8;
    localparam int unsigned MB     = MDW / 8;
    localparam bit          NARROW = SB > MB;
    localparam int unsigned NSEG   = NARROW ? SB / MB : 1;
    localparam int          NREADS = 60;

    logic           rst;
    logic [31:0]    s_araddr;
    logic [2:0]     s_arprot;
    logic           s_arvalid, s_arready;
    logic [SDW-1:0] s_rdata;
    logic [1:0]     s_rresp;
    logic           s_rvalid, s_rready;
    logic [31:0]    m_araddr;
    logic [2:0]     m_arprot;
    logic           m_arvalid, m_arready;
    logic [MDW-1:0] m_rdata;
    logic [1:0]     m_rresp;
    logic           m_rvalid, m_rready;

    s_exp_t sq[$];
    m_exp_t mq[$];

    axil_adapter_rd #(
      .ADDR_WIDTH  (32),
      .S_DATA_WIDTH(SDW),
      .M_DATA_WIDTH(MDW)
    ) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axil_araddr (s_araddr),
      .s_axil_arprot (s_arprot),
      .s_axil_arvalid(s_arvalid),
      .s_axil_arready(s_arready),
      .s_axil_rdata  (s_rdata),
      .s_axil_rresp  (s_rresp),
      .s_axil_rvalid (s_rvalid),
      .s_axil_rready (s_rready),
      .m_axil_araddr (m_araddr),
      .m_axil_arprot (m_arprot),
      .m_axil_arvalid(m_arvalid),
      .m_axil_arready(m_arready),
      .m_axil_rdata  (m_rdata),
      .m_axil_rresp  (m_rresp),
      .m_axil_rvalid (m_rvalid),
      .m_axil_rready (m_rready)
    );

    function automatic string nm(input string s);
      return $sformatf("cfg%0d(S%0d/M%0d) %s", g, SDW, MDW, s);
    endfunction

    // Present one slave read and record what the master and slave sides must see
    task automatic issue(input logic [31:0] a);
      int          t;
      logic [2:0]  p;
      logic [31:0] base;
      logic [1:0]  acc, r;
      s_exp_t      e;
      m_exp_t      me;
      p = 3'($urandom);
      s_araddr  = a;
      s_arprot  = p;
      s_arvalid = 1'b1;
      t = 0;
      while (!s_arready && t < 500) begin
        @(negedge clk);
        t++;
      end
      if (!s_arready) begin
        flag(nm("s_arready timeout"));
      end else begin
        e.data = busword(a, SB);
        me.prot = p;
        if (NARROW) begin
          base = a & ~32'(SB - 1);
          acc  = 2'd0;
          for (int i = 0; i < int'(NSEG); i++) begin
            me.addr = base + 32'(i * int'(MB));
            mq.push_back(me);
            r = respfn(me.addr);
            if (r != 2'd0) acc = r;
          end
          e.resp = acc;
        end else begin
          me.addr = a;
          mq.push_back(me);
          e.resp = respfn(a & ~32'(MB - 1));
        end
        sq.push_back(e);
      end
      @(negedge clk);
      s_arvalid = 1'b0;
    endtask

    task automatic drain();
      int t;
      t = 0;
      while ((sq.size() != 0 || mq.size() != 0) && t < 4000) begin
        @(negedge clk);
        t++;
      end
      check(nm("outstanding after drain"), 128'(sq.size() + mq.size()), 128'd0);
    endtask

    task automatic reset_outputs_zero(input string tag);
      check(nm({tag, " s_arready"}), 128'(s_arready), 128'd0);
      check(nm({tag, " s_rvalid"}),  128'(s_rvalid),  128'd0);
      check(nm({tag, " m_arvalid"}), 128'(m_arvalid), 128'd0);
      check(nm({tag, " m_rready"}),  128'(m_rready),  128'd0);
      check(nm({tag, " s_rdata"}),   128'(s_rdata),   128'd0);
    endtask

    // Slave-side driver: reset, random reads, mid-transaction reset, fresh reads
    initial begin : drv
      logic [31:0] a;
      rst = 1'b0;
      s_arvalid = 1'b0;
      s_araddr  = '0;
      s_arprot  = '0;
      repeat (3) @(negedge clk);
      reset_outputs_zero("reset");
      check(nm("reset m_araddr"), 128'(m_araddr), 128'd0);
      rst = 1'b1;
      check(nm("release s_arready before edge"), 128'(s_arready), 128'd0);
      @(negedge clk);
      check(nm("release s_arready after edge"), 128'(s_arready), 128'd1);
      for (int k = 0; k < NREADS; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        if (k < 4)                         a = 32'h1000 + 32'(4 * k);
        else if ($urandom_range(0, 3) == 0) a = $urandom;
        else                               a = 32'h1000 + 32'($urandom_range(0, 255));
        issue(a);
      end
      drain();
      issue(32'h2004);
      #2 rst = 1'b0;
      #1 reset_outputs_zero("mid-read reset");
      sq.delete();
      mq.delete();
      repeat (2) @(negedge clk);
      rst = 1'b1;
      check(nm("re-release s_arready before edge"), 128'(s_arready), 128'd0);
      @(negedge clk);
      check(nm("re-release s_arready after edge"), 128'(s_arready), 128'd1);
      for (int k = 0; k < 4; k++) issue(32'h3000 + 32'($urandom_range(0, 63)));
      drain();
      done_cnt++;
    end

    // Master-side memory: random AR stall and R latency, checks forwarded addresses
    initial begin : mem
      int          rs, stall, dly;
      logic        have;
      logic [31:0] ca;
      logic [2:0]  cp;
      m_exp_t      me;
      rs = 0; stall = 0; dly = 0; have = 1'b0; ca = '0; cp = '0;
      m_arready = 1'b0;
      m_rvalid  = 1'b0;
      m_rdata   = '0;
      m_rresp   = 2'd0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          rs = 0;
          have = 1'b0;
          m_arready = 1'b0;
          m_rvalid  = 1'b0;
        end else begin
          case (rs)
            0: if (have || m_arvalid) begin
              if (!have) begin
                have  = 1'b1;
                ca    = m_araddr;
                cp    = m_arprot;
                stall = ($urandom_range(0, 4) == 0) ? 4 : int'($urandom_range(0, 1));
                if (mq.size() == 0) begin
                  flag(nm("unexpected master AR"));
                end else begin
                  me = mq.pop_front();
                  check(nm("m_araddr"), 128'(m_araddr), 128'(me.addr));
                  check(nm("m_arprot"), 128'(m_arprot), 128'(me.prot));
                end
              end else begin
                check(nm("m_arvalid held in stall"), 128'(m_arvalid), 128'd1);
                check(nm("m_araddr held in stall"),  128'(m_araddr),  128'(ca));
                check(nm("s_arready low in stall"),  128'(s_arready), 128'd0);
              end
              if (stall == 0) begin
                m_arready = 1'b1;
                rs = 1;
              end else begin
                stall--;
              end
            end
            1: begin
              m_arready = 1'b0;
              have = 1'b0;
              dly = int'($urandom_range(0, 2));
              rs = 2;
            end
            2: if (dly == 0) begin
              m_rvalid = 1'b1;
              m_rdata  = MDW'(busword(ca, MB));
              m_rresp  = respfn(ca & ~32'(MB - 1));
              rs = 3;
            end else begin
              dly--;
            end
            4: begin
              m_rvalid = 1'b0;
              m_rdata  = MDW'({$urandom, $urandom, $urandom, $urandom});
              m_rresp  = 2'($urandom);
              rs = 0;
            end
            default: ;
          endcase
          if (rs == 3 && m_rready) rs = 4;
        end
      end
    end

    // Slave R monitor: random backpressure, hold checks, scoreboard compare
    initial begin : rmon
      int             bp;
      logic           hold;
      logic [SDW-1:0] hd;
      logic [1:0]     hr;
      s_exp_t         e;
      bp = 0; hold = 1'b0; hd = '0; hr = '0;
      s_rready = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst) begin
          s_rready = 1'b0;
          hold = 1'b0;
          bp = 0;
        end else begin
          if (hold) begin
            check(nm("s_rvalid held"), 128'(s_rvalid), 128'd1);
            check(nm("s_rdata held"),  128'(s_rdata),  128'(hd));
            check(nm("s_rresp held"),  128'(s_rresp),  128'(hr));
          end
          if (s_rvalid) check(nm("m_rready while s_rvalid"), 128'(m_rready), 128'd0);
          if (bp > 0) begin
            s_rready = 1'b0;
            bp--;
          end else if ($urandom_range(0, 9) == 0) begin
            s_rready = 1'b0;
            bp = 4;
          end else begin
            s_rready = ($urandom_range(0, 3) != 0);
          end
          if (s_rvalid && s_rready) begin
            if (sq.size() == 0) begin
              flag(nm("unexpected s_rvalid"));
            end else begin
              e = sq.pop_front();
              check(nm("s_rdata"), 128'(s_rdata), e.data);
              check(nm("s_rresp"), 128'(s_rresp), 128'(e.resp));
            end
          end
          hold = s_rvalid && !s_rready;
          hd = s_rdata;
          hr = s_rresp;
        end
      end
    end
  end

  initial begin : main
    int cyc;
    cyc = 0;
    while (done_cnt < 5 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    if (done_cnt < 5) flag($sformatf("watchdog: %0d of 5 configurations finished", done_cnt));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
